// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_pkg;

  localparam int unsigned MAX_BYTES       = 8;
  localparam int unsigned BYTES_W         = MAX_BYTES * 8;
  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd50000;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } txnState_t;

  // Lengths the master cannot execute: empty write or anything beyond the byte buffer.
  function automatic logic lenInvalid(input logic [3:0] wrLen, input logic [3:0] rdLen);
    return (wrLen == 4'd0) || (wrLen > 4'(MAX_BYTES)) || (rdLen > 4'(MAX_BYTES));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after LastGrant, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] Req,
  input  logic [IDXW-1:0] LastGrant,
  output logic [NREQ-1:0] GrantOh,
  output logic [IDXW-1:0] GrantIdx,
  output logic            GrantValid
);

  logic [IDXW-1:0] cand;

  always_comb begin
    GrantOh    = '0;
    GrantIdx   = '0;
    GrantValid = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDXW'((32'(LastGrant) + i) % NREQ);
      if (!GrantValid && Req[cand]) begin
        GrantValid    = 1'b1;
        GrantIdx      = cand;
        GrantOh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates NREQ requesters onto one I2C master: grant, launch, wait, acknowledge,
// with per-phase timeout and length validation at grant.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*BYTES_W-1:0]   ReqWrBytes,
  input  logic [NREQ*4-1:0]         ReqWrLen,
  input  logic [NREQ*4-1:0]         ReqRdLen,
  output logic [NREQ-1:0]           Ack,
  output logic                      Err,
  output logic [BYTES_W-1:0]        RdData,
  output logic                      Busy,
  output logic [BYTES_W-1:0]        MWrBytes,
  output logic [7:0]                MWrLen,
  output logic [7:0]                MRdLen,
  output logic                      MStartReq,
  input  logic                      MRdy,
  input  logic [BYTES_W-1:0]        MRdBytes
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][BYTES_W-1:0] wrBytesArr;
  logic [NREQ-1:0][3:0]         wrLenArr;
  logic [NREQ-1:0][3:0]         rdLenArr;

  assign wrBytesArr = ReqWrBytes;
  assign wrLenArr   = ReqWrLen;
  assign rdLenArr   = ReqRdLen;

  txnState_t          state, stateNext;
  logic [IDXW-1:0]    lastGrant, lastGrantNext;
  logic [IDXW-1:0]    grantIdx, grantIdxNext;
  logic [NREQ-1:0]    grantOh, grantOhNext;
  logic [15:0]        cnt, cntNext;
  logic [NREQ-1:0]    ackNext;
  logic               errNext, busyNext, startNext;
  logic [BYTES_W-1:0] wrBytesNext, rdDataNext;
  logic [7:0]         wrLenNext, rdLenNext;
  logic [NREQ-1:0]    arbOh;
  logic [IDXW-1:0]    arbIdx;
  logic               arbValid;
  logic               timeoutHit;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) uArb (
    .Req       (Req),
    .LastGrant (lastGrant),
    .GrantOh   (arbOh),
    .GrantIdx  (arbIdx),
    .GrantValid(arbValid)
  );

  // Phase counter is zero on phase entry, so TIMEOUT cycles elapse at TIMEOUT-1.
  assign timeoutHit = (cnt == TIMEOUT - 16'd1);

  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    grantIdxNext  = grantIdx;
    grantOhNext   = grantOh;
    cntNext       = cnt;
    ackNext       = '0;
    errNext       = 1'b0;
    busyNext      = Busy;
    startNext     = 1'b0;
    wrBytesNext   = MWrBytes;
    wrLenNext     = MWrLen;
    rdLenNext     = MRdLen;
    rdDataNext    = RdData;

    unique case (state)
      IDLE: begin
        if (arbValid && MRdy) begin
          grantIdxNext = arbIdx;
          grantOhNext  = arbOh;
          wrBytesNext  = wrBytesArr[arbIdx];
          wrLenNext    = {4'b0000, wrLenArr[arbIdx]};
          rdLenNext    = {4'b0000, rdLenArr[arbIdx]};
          busyNext     = 1'b1;
          cntNext      = '0;
          if (lenInvalid(wrLenArr[arbIdx], rdLenArr[arbIdx])) begin
            stateNext = DONE;
            ackNext   = arbOh;
            errNext   = 1'b1;
          end else begin
            stateNext = LAUNCH;
            startNext = 1'b1;
          end
        end
      end

      LAUNCH: begin
        if (!MRdy) begin
          stateNext = WAIT;
          cntNext   = '0;
        end else if (timeoutHit) begin
          stateNext = DONE;
          ackNext   = grantOh;
          errNext   = 1'b1;
        end else begin
          startNext = 1'b1;
          cntNext   = cnt + 16'd1;
        end
      end

      WAIT: begin
        if (MRdy) begin
          stateNext  = DONE;
          rdDataNext = MRdBytes;
          ackNext    = grantOh;
        end else if (timeoutHit) begin
          stateNext = DONE;
          ackNext   = grantOh;
          errNext   = 1'b1;
        end else begin
          cntNext = cnt + 16'd1;
        end
      end

      DONE: begin
        lastGrantNext = grantIdx;
        busyNext      = 1'b0;
        stateNext     = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      lastGrant <= IDXW'(NREQ - 1);
      grantIdx  <= '0;
      grantOh   <= '0;
      cnt       <= '0;
      Ack       <= '0;
      Err       <= 1'b0;
      Busy      <= 1'b0;
      MStartReq <= 1'b0;
      MWrBytes  <= '0;
      MWrLen    <= '0;
      MRdLen    <= '0;
      RdData    <= '0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      grantIdx  <= grantIdxNext;
      grantOh   <= grantOhNext;
      cnt       <= cntNext;
      Ack       <= ackNext;
      Err       <= errNext;
      Busy      <= busyNext;
      MStartReq <= startNext;
      MWrBytes  <= wrBytesNext;
      MWrLen    <= wrLenNext;
      MRdLen    <= rdLenNext;
      RdData    <= rdDataNext;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a scripted I2C master.
module tb_i2c_txn_arbiter;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [3:0]       Req = '0;
  logic [3:0][63:0] wrBytes = '0;
  logic [3:0][3:0]  wrLen = '0;
  logic [3:0][3:0]  rdLen = '0;
  logic             MRdy = 1'b1;
  logic [63:0]      MRdBytes = '0;
  logic [3:0]       Ack;
  logic             Err;
  logic [63:0]      RdData;
  logic             Busy;
  logic [63:0]      MWrBytes;
  logic [7:0]       MWrLen;
  logic [7:0]       MRdLen;
  logic             MStartReq;

  int nVec = 0;
  int nFail = 0;

  i2c_txn_arbiter #(.NREQ(4), .TIMEOUT(16'd100)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWrBytes(wrBytes), .ReqWrLen(wrLen),
    .ReqRdLen(rdLen), .Ack(Ack), .Err(Err), .RdData(RdData), .Busy(Busy),
    .MWrBytes(MWrBytes), .MWrLen(MWrLen), .MRdLen(MRdLen), .MStartReq(MStartReq),
    .MRdy(MRdy), .MRdBytes(MRdBytes)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic resetDut();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Master: sees start, drops MRdy 2 cycles later, raises it with data 20 cycles after.
  task automatic masterRespond(input logic [63:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (MStartReq) ok = 1'b1;
      else @(negedge Clk);
    end
    if (ok) begin
      tick(2);
      MRdy = 1'b0;
      tick(20);
      MRdBytes = data;
      MRdy = 1'b1;
    end
  endtask

  task automatic waitAck(input int budget, output logic [3:0] a, output logic e,
                         output logic [63:0] rd, output bit seen, output bit sawStart);
    seen = 1'b0; sawStart = 1'b0; a = '0; e = 1'b0; rd = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clk);
      if (MStartReq) sawStart = 1'b1;
      if (Ack != 4'b0000) begin
        seen = 1'b1; a = Ack; e = Err; rd = RdData;
      end
    end
  endtask

  task automatic test_reset();
    tick(2);
    nVec++; if (Ack !== 4'b0000) begin nFail++; $display("FAIL reset_ack: got %b expected 0000", Ack); end
    nVec++; if ({Busy, MStartReq, Err} !== 3'b000) begin nFail++; $display("FAIL reset_ctl: got %b expected 000", {Busy, MStartReq, Err}); end
    nVec++; if ({MWrLen, MRdLen} !== 16'h0000) begin nFail++; $display("FAIL reset_len: got %h expected 0000", {MWrLen, MRdLen}); end
    nVec++; if ({MWrBytes, RdData} !== 128'h0) begin nFail++; $display("FAIL reset_data: got %h expected 0", {MWrBytes, RdData}); end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok, seen, st;
    logic [3:0] a; logic e; logic [63:0] rd;
    int extra;
    wrBytes[0] = 64'h0000_0000_0000_0070; wrLen[0] = 4'd2; rdLen[0] = 4'd0;
    @(negedge Clk);
    Req[0] = 1'b1;
    nVec++; if (MStartReq !== 1'b0) begin nFail++; $display("FAIL single_start_early: got %b expected 0", MStartReq); end
    @(negedge Clk);
    nVec++; if ({MStartReq, Busy} !== 2'b11) begin nFail++; $display("FAIL single_start_latency: got %b expected 11", {MStartReq, Busy}); end
    nVec++; if ({MWrLen, MRdLen, MWrBytes[15:0]} !== 32'h0200_0070) begin nFail++; $display("FAIL single_mbus: got %h expected 02000070", {MWrLen, MRdLen, MWrBytes[15:0]}); end
    masterRespond(64'h0, ok);
    nVec++; if (!ok) begin nFail++; $display("FAIL single_start_seen: got 0 expected 1"); end
    waitAck(60, a, e, rd, seen, st);
    Req[0] = 1'b0;
    nVec++; if ({seen, a, e} !== 6'b1_0001_0) begin nFail++; $display("FAIL single_ack: got %b expected 100010", {seen, a, e}); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Ack != 4'b0000) extra++;
    end
    nVec++; if (extra !== 0 || Busy !== 1'b0) begin nFail++; $display("FAIL single_once: got extra=%0d busy=%b expected 0 0", extra, Busy); end
  endtask

  task automatic test_back_to_back();
    int expIdx[4] = '{1, 3, 1, 3};
    bit ok, seen, st;
    logic [3:0] a, expOh; logic e; logic [63:0] rd, data;
    resetDut();
    wrBytes[1] = 64'h0000_0000_0000_00A1; wrLen[1] = 4'd1; rdLen[1] = 4'd2;
    wrBytes[3] = 64'h0000_0000_0000_00A3; wrLen[3] = 4'd1; rdLen[3] = 4'd2;
    @(negedge Clk);
    Req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      data = {48'h0, 8'hA5, 8'(k)};
      expOh = 4'b0001 << expIdx[k];
      masterRespond(data, ok);
      nVec++; if (MRdLen !== 8'd2 || !ok) begin nFail++; $display("FAIL b2b_launch%0d: got rdlen=%h ok=%b expected 02 1", k, MRdLen, ok); end
      waitAck(60, a, e, rd, seen, st);
      if (k == 3) Req = 4'b0000;
      nVec++; if ({seen, a, e} !== {1'b1, expOh, 1'b0}) begin nFail++; $display("FAIL b2b_order%0d: got %b expected %b", k, {seen, a, e}, {1'b1, expOh, 1'b0}); end
      nVec++; if (rd !== data || rd[15:8] !== 8'hA5) begin nFail++; $display("FAIL b2b_rddata%0d: got %h expected %h", k, rd, data); end
    end
    tick(2);
  endtask

  task automatic test_invalid();
    logic [3:0] wl[3] = '{4'd0, 4'd9, 4'd1};
    logic [3:0] rl[3] = '{4'd0, 4'd0, 4'd9};
    bit seen, st;
    logic [3:0] a; logic e; logic [63:0] rd;
    for (int k = 0; k < 3; k++) begin
      wrLen[2] = wl[k]; rdLen[2] = rl[k];
      @(negedge Clk);
      Req[2] = 1'b1;
      waitAck(10, a, e, rd, seen, st);
      Req[2] = 1'b0;
      nVec++; if ({seen, a, e} !== 6'b1_0100_1) begin nFail++; $display("FAIL invalid_ack%0d: got %b expected 101001", k, {seen, a, e}); end
      nVec++; if (st !== 1'b0) begin nFail++; $display("FAIL invalid_nostart%0d: got %b expected 0", k, st); end
    end
    tick(2);
  endtask

  task automatic test_timeout();
    int hiCnt;
    logic [3:0] a; logic e; logic [63:0] rd;
    wrLen[0] = 4'd1; rdLen[0] = 4'd1; MRdy = 1'b1;
    @(negedge Clk);
    Req[0] = 1'b1;
    for (int i = 0; i < 5 && !MStartReq; i++) @(negedge Clk);
    hiCnt = 0;
    while (MStartReq && hiCnt < 300) begin
      hiCnt++;
      @(negedge Clk);
    end
    a = Ack; e = Err; rd = RdData;
    Req[0] = 1'b0;
    nVec++; if (hiCnt !== 100) begin nFail++; $display("FAIL timeout_cycles: got %0d expected 100", hiCnt); end
    nVec++; if ({a, e} !== 5'b0001_1) begin nFail++; $display("FAIL timeout_ack: got %b expected 00011", {a, e}); end
    nVec++; if (rd !== 64'h0000_0000_0000_A503) begin nFail++; $display("FAIL timeout_rddata: got %h expected 000000000000a503", rd); end
    tick(2);
  endtask

  task automatic test_reset_in_wait();
    bit ok, seen, st;
    int acks;
    logic [3:0] a; logic e; logic [63:0] rd;
    wrLen[1] = 4'd1; rdLen[1] = 4'd1;
    @(negedge Clk);
    Req[1] = 1'b1;
    for (int i = 0; i < 5 && !MStartReq; i++) @(negedge Clk);
    tick(2);
    MRdy = 1'b0;
    tick(5);
    nVec++; if ({Busy, MStartReq} !== 2'b10) begin nFail++; $display("FAIL rstwait_pre: got %b expected 10", {Busy, MStartReq}); end
    #2 Reset = 1'b1;
    #1;
    nVec++; if ({MStartReq, Busy, Err, Ack} !== 7'b0) begin nFail++; $display("FAIL rstwait_ctl: got %b expected 0000000", {MStartReq, Busy, Err, Ack}); end
    nVec++; if ({MWrLen, MRdLen, MWrBytes, RdData} !== 144'h0) begin nFail++; $display("FAIL rstwait_data: got %h expected 0", {MWrLen, MRdLen, MWrBytes, RdData}); end
    Req[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 2; i++) begin @(negedge Clk); if (Ack != 4'b0000) acks++; end
    Reset = 1'b0;
    MRdy = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge Clk); if (Ack != 4'b0000) acks++; end
    nVec++; if (acks !== 0) begin nFail++; $display("FAIL rstwait_noack: got %0d expected 0", acks); end
    wrLen[2] = 4'd3; rdLen[2] = 4'd0;
    Req[2] = 1'b1;
    masterRespond(64'h0000_0000_0000_1234, ok);
    waitAck(60, a, e, rd, seen, st);
    Req[2] = 1'b0;
    nVec++; if ({ok, seen, a, e} !== 7'b11_0100_0) begin nFail++; $display("FAIL rstwait_regrant: got %b expected 1101000", {ok, seen, a, e}); end
    tick(2);
  endtask

  task automatic test_drop_in_launch();
    bit ok, seen, st;
    int extra;
    logic [3:0] a; logic e; logic [63:0] rd;
    wrLen[0] = 4'd2; rdLen[0] = 4'd1;
    @(negedge Clk);
    Req[0] = 1'b1;
    @(negedge Clk);
    nVec++; if (MStartReq !== 1'b1) begin nFail++; $display("FAIL drop_launch: got %b expected 1", MStartReq); end
    Req[0] = 1'b0;
    masterRespond(64'h0000_0000_0000_005A, ok);
    waitAck(60, a, e, rd, seen, st);
    nVec++; if ({ok, seen, a, e} !== 7'b11_0001_0 || rd !== 64'h5A) begin nFail++; $display("FAIL drop_ack: got %b rd=%h expected 1100010 rd=5a", {ok, seen, a, e}, rd); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin @(negedge Clk); if (Ack != 4'b0000) extra++; end
    nVec++; if (extra !== 0) begin nFail++; $display("FAIL drop_once: got %0d expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_timeout();
    test_reset_in_wait();
    test_drop_in_launch();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
